fir_reload_ctrl: RTL and testbench

- Sequences a run-time coefficient reload of the FIR/correlator in the channel-sounder datapath.
- On a start pulse it reads NUM_COEF words from the coefficient ROM, streams them on the FIR reload AXI-Stream channel with tlast on the final word, then issues one config-channel beat to apply the new set.
- It also monitors the FIR reload event outputs and reports aborts.
- Sits between the PS-side control registers and the FIR compiler reload/config ports.

---
 rtl/fir_reload_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_fir_reload_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_reload_ctrl.sv
// fir_reload_ctrl: streams a coefficient set from ROM to the FIR reload port, then
// applies it with one config beat. Define RELOAD_CHECKSUM_EN to add reload_sum.
module fir_reload_ctrl #(
  parameter int ADDR_WIDTH  = 11,
  parameter int COEF_WIDTH  = 16,
  parameter int NUM_COEF    = 1024,
  parameter int ROM_LATENCY = 2
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] coef_base,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [COEF_WIDTH-1:0] rom_data,
  output logic [COEF_WIDTH-1:0] m_axis_reload_tdata,
  output logic                  m_axis_reload_tvalid,
  input  logic                  m_axis_reload_tready,
  output logic                  m_axis_reload_tlast,
  output logic [7:0]            m_axis_config_tdata,
  output logic                  m_axis_config_tvalid,
  input  logic                  m_axis_config_tready,
  input  logic                  event_s_reload_tlast_missing,
  input  logic                  event_s_reload_tlast_unexpected
`ifdef RELOAD_CHECKSUM_EN
  ,
  output logic [31:0]           reload_sum
`endif
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] NUM = CNT_W'(NUM_COEF);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CONFIG,
    S_DONE,
    S_ABORT
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    err_q, err_d;
  logic                    hold_q, hold_d;
  logic [CNT_W-1:0]        iss_q, iss_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [ROM_LATENCY-1:0]  pipe_q, pipe_d;
  logic [COEF_WIDTH-1:0]   mem_q [4];
  logic [COEF_WIDTH-1:0]   mem_d [4];
  logic [1:0]              wp_q, wp_d;
  logic [1:0]              rp_q, rp_d;
  logic [2:0]              cnt_q, cnt_d;

  logic [2:0] infl;
  logic       fetch, stop, rvalid, rpop, rlast, en, wr;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    err_d   = err_q;
    hold_d  = hold_q;
    iss_d   = iss_q;
    beat_d  = beat_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    mem_d   = mem_q;
    pipe_d  = '0;
    infl    = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      infl = infl + {2'b00, pipe_q[i]};
    end
    fetch  = state_q == S_FETCH;
    stop   = hold_q | event_s_reload_tlast_missing
           | event_s_reload_tlast_unexpected;
    rvalid = fetch && cnt_q != 3'd0;
    rpop   = rvalid && m_axis_reload_tready;
    rlast  = rvalid && beat_q == LAST_IDX;
    en     = fetch && !stop && (cnt_q + infl < 3'd4) && iss_q < NUM;
    // an abort drops whatever the ROM still has in flight
    wr     = fetch && !stop && pipe_q[ROM_LATENCY-1];

    pipe_d[0] = en;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (en) iss_d = iss_q + CNT_W'(1);
    if (wr) begin
      mem_d[wp_q] = rom_data;
      wp_d = wp_q + 2'd1;
    end
    if (rpop) begin
      rp_d   = rp_q + 2'd1;
      beat_d = beat_q + CNT_W'(1);
    end
    cnt_d = cnt_q + {2'b00, wr} - {2'b00, rpop};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = coef_base;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (stop) begin
          err_d = 1'b1;
          if (rvalid && !m_axis_reload_tready) hold_d = 1'b1;
          else state_d = S_ABORT;
        end else if (rpop && rlast) begin
          state_d = S_CONFIG;
        end
      end
      S_CONFIG: begin
        if (stop) begin
          err_d = 1'b1;
          if (!m_axis_config_tready) hold_d = 1'b1;
          else state_d = S_ABORT;
        end else if (m_axis_config_tready) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: begin
        hold_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!fetch) begin
      iss_d  = '0;
      beat_d = '0;
      pipe_d = '0;
      wp_d   = '0;
      rp_d   = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      iss_q   <= '0;
      beat_q  <= '0;
      pipe_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      iss_q   <= iss_d;
      beat_q  <= beat_d;
      pipe_q  <= pipe_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign busy                 = fetch || state_q == S_CONFIG;
  assign done                 = state_q == S_DONE;
  assign err                  = err_q;
  assign rom_en               = en;
  assign rom_addr             = base_q + iss_q[ADDR_WIDTH-1:0];
  assign m_axis_reload_tvalid = rvalid;
  assign m_axis_reload_tdata  = rvalid ? mem_q[rp_q] : '0;
  assign m_axis_reload_tlast  = rlast;
  assign m_axis_config_tdata  = 8'h00;
  assign m_axis_config_tvalid = state_q == S_CONFIG;

`ifdef RELOAD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE && start) sum_d = '0;
    else if (rpop) sum_d = sum_q + 32'(m_axis_reload_tdata);
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) sum_q <= '0;
    else sum_q <= sum_d;
  end

  assign reload_sum = sum_q;
`endif

endmodule

// File: tb/tb_fir_reload_ctrl.sv
// tb_fir_reload_ctrl: directed reload runs (NUM_COEF=8, ROM latency 2)
// against a ROM holding addr+1 at every address.
module tb_fir_reload_ctrl;

  localparam int AW = 11;
  localparam int CW = 16;
  localparam int NC = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] coef_base = '0;
  logic          busy, done, err, rom_en;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_data, r1;
  logic [CW-1:0] tdata;
  logic          tvalid, tready, tlast;
  logic [7:0]    cfg_tdata;
  logic          cfg_tvalid, cfg_tready;
  logic          ev_miss = 1'b0;
  logic          ev_unexp = 1'b0;
`ifdef RELOAD_CHECKSUM_EN
  logic [31:0]   reload_sum;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   s_cyc = 0;
  int   mode = 0;
  logic tog = 1'b0;
  logic tr_man = 1'b1;

  assign tready     = mode == 0 ? 1'b1 : mode == 1 ? tog : tr_man;
  assign cfg_tready = mode == 1 ? tog : 1'b1;

  fir_reload_ctrl #(
    .ADDR_WIDTH (AW),
    .COEF_WIDTH (CW),
    .NUM_COEF   (NC),
    .ROM_LATENCY(RL)
  ) dut (
    .m00_axis_aclk                  (clk),
    .m00_axis_aresetn               (rst_n),
    .start                          (start),
    .coef_base                      (coef_base),
    .busy                           (busy),
    .done                           (done),
    .err                            (err),
    .rom_addr                       (rom_addr),
    .rom_en                         (rom_en),
    .rom_data                       (rom_data),
    .m_axis_reload_tdata            (tdata),
    .m_axis_reload_tvalid           (tvalid),
    .m_axis_reload_tready           (tready),
    .m_axis_reload_tlast            (tlast),
    .m_axis_config_tdata            (cfg_tdata),
    .m_axis_config_tvalid           (cfg_tvalid),
    .m_axis_config_tready           (cfg_tready),
    .event_s_reload_tlast_missing   (ev_miss),
    .event_s_reload_tlast_unexpected(ev_unexp)
`ifdef RELOAD_CHECKSUM_EN
    ,
    .reload_sum                     (reload_sum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tog      <= ~tog;
    cyc      <= cyc + 1;
    r1       <= 16'(rom_addr) + 16'd1;
    rom_data <= r1;
  end

  logic [CW-1:0] bdata[$];
  logic          blast[$];
  int            bcyc[$];
  logic [AW-1:0] addrq[$];
  int            ncfg = 0, cfg_bad = 0, ndone = 0, db_bad = 0;
  int            stall_bad = 0, ovl_bad = 0, out_n = 0, max_out = 0;
  logic          pstall = 1'b0;
  logic          plast = 1'b0;
  logic [CW-1:0] pdata = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pstall <= 1'b0;
      out_n  <= 0;
    end else begin
      if (pstall && !(tvalid && tdata == pdata && tlast == plast))
        stall_bad <= stall_bad + 1;
      pstall <= tvalid && !tready;
      pdata  <= tdata;
      plast  <= tlast;
      if (tvalid && tready) begin
        bdata.push_back(tdata);
        blast.push_back(tlast);
        bcyc.push_back(cyc);
      end
      if (rom_en) addrq.push_back(rom_addr);
      if (cfg_tvalid && cfg_tready) ncfg <= ncfg + 1;
      if (cfg_tvalid && cfg_tready && cfg_tdata != 8'h00)
        cfg_bad <= cfg_bad + 1;
      if (cfg_tvalid && tvalid) ovl_bad <= ovl_bad + 1;
      if (done) ndone <= ndone + 1;
      if (done && busy) db_bad <= db_bad + 1;
      out_n <= !busy ? 0
             : out_n + int'(rom_en) - int'(tvalid && tready);
      if (busy && out_n + int'(rom_en) > max_out)
        max_out <= out_n + int'(rom_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    coef_base = b;
    start     = 1'b1;
    s_cyc     = cyc;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string t);
    int k;
    k = 0;
    while (busy && k < 400) begin
      step();
      k++;
    end
    chk({t, "_no_timeout"}, 32'(k < 400), 1);
  endtask

  task automatic chk_beats(input string t, input int b0,
                           input int base, input int n);
    chk({t, "_count"}, 32'(bdata.size() - b0), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (b0 + i < bdata.size()) begin
        chk($sformatf("%s_data%0d", t, i), 32'(bdata[b0+i]),
            32'(((base + i) % 2048) + 1));
        chk($sformatf("%s_last%0d", t, i), 32'(blast[b0+i]),
            32'(i == NC - 1));
      end
    end
  endtask

  task automatic full_run(input string t, input logic [AW-1:0] base,
                          output int b0);
    int c0, d0;
    b0 = bdata.size();
    c0 = ncfg;
    d0 = ndone;
    do_start(base);
    chk({t, "_busy_up"}, 32'(busy), 1);
    wait_idle(t);
    step();
    step();
    chk_beats(t, b0, int'(base), NC);
    chk({t, "_cfg_beats"}, 32'(ncfg - c0), 1);
    chk({t, "_done_pulses"}, 32'(ndone - d0), 1);
    chk({t, "_err"}, 32'(err), 0);
    chk({t, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    int b0, c0, d0, a0, k;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_cfg_tvalid", 32'(cfg_tvalid), 0);
    rst_n = 1'b1;
    step();

    mode = 0;
    full_run("t1", 11'd0, b0);
    chk("t1_first_tvalid_lat", 32'(bcyc[b0] - s_cyc - 1), 32'(RL + 1));
    chk("t1_throughput", 32'(bcyc[b0+NC-1] - bcyc[b0]), 32'(NC - 1));
`ifdef RELOAD_CHECKSUM_EN
    chk("t1_sum", reload_sum, 36);
`endif

    mode = 1;
    full_run("t2", 11'd0, b0);
    chk("t2_stall_stable", 32'(stall_bad), 0);
    chk("t2_max_outstanding_le4", 32'(max_out <= 4), 1);

    mode = 0;
    a0 = addrq.size();
    full_run("t3", 11'd2045, b0);
    chk("t3_issued", 32'(addrq.size() - a0), 32'(NC));
    for (int i = 0; i < NC; i++) begin
      if (a0 + i < addrq.size())
        chk($sformatf("t3_addr%0d", i), 32'(addrq[a0+i]),
            32'((2045 + i) % 2048));
    end
`ifdef RELOAD_CHECKSUM_EN
    chk("t3_sum", reload_sum, 6156);
`endif

    mode   = 2;
    tr_man = 1'b1;
    b0 = bdata.size();
    c0 = ncfg;
    d0 = ndone;
    do_start(11'd0);
    k = 0;
    while (bdata.size() - b0 < 3 && k < 50) begin
      step();
      k++;
    end
    chk("t4_reach_beat3", 32'(k < 50), 1);
    tr_man   = 1'b0;
    ev_unexp = 1'b1;
    step();
    ev_unexp = 1'b0;
    chk("t4_err_set", 32'(err), 1);
    chk("t4_held_valid", 32'(tvalid), 1);
    chk("t4_held_data", 32'(tdata), 4);
    chk("t4_busy_hold", 32'(busy), 1);
    step();
    chk("t4_held_valid2", 32'(tvalid), 1);
    chk("t4_held_data2", 32'(tdata), 4);
    tr_man = 1'b1;
    step();
    chk("t4_busy_drop", 32'(busy), 0);
    chk("t4_tvalid_drop", 32'(tvalid), 0);
    step();
    step();
    step();
    chk_beats("t4", b0, 0, 4);
    chk("t4_no_cfg", 32'(ncfg - c0), 0);
    chk("t4_no_done", 32'(ndone - d0), 0);
    chk("t4_err_sticky", 32'(err), 1);
    chk("t4_rom_en_idle", 32'(rom_en), 0);
`ifdef RELOAD_CHECKSUM_EN
    chk("t4_partial_sum", reload_sum, 10);
`endif

    mode = 0;
    b0 = bdata.size();
    d0 = ndone;
    do_start(11'd0);
    chk("t5_err_cleared", 32'(err), 0);
    step();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t5");
    step();
    step();
    chk_beats("t5", b0, 0, NC);
    chk("t5_done_once", 32'(ndone - d0), 1);
    full_run("t5b", 11'd0, b0);

    b0 = bdata.size();
    do_start(11'd0);
    k = 0;
    while (bdata.size() - b0 < 3 && k < 50) begin
      step();
      k++;
    end
    chk("t6_reach_beat3", 32'(k < 50), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(tvalid), 0);
    chk("t6_rst_rom_en", 32'(rom_en), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();
    full_run("t6", 11'd0, b0);
`ifdef RELOAD_CHECKSUM_EN
    chk("t6_sum", reload_sum, 36);
`endif

    chk("cfg_tdata_zero", 32'(cfg_bad), 0);
    chk("cfg_reload_overlap", 32'(ovl_bad), 0);
    chk("done_with_busy", 32'(db_bad), 0);
    chk("stall_stable_all", 32'(stall_bad), 0);
    chk("max_outstanding_all", 32'(max_out <= 4), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
